// File: rtl/wb_ram_bist_master.sv
// Wishbone classic initiator that writes a generated pattern to a RAM window and
// reads it back, reporting mismatch count, first failing address and ack timeouts.
module wb_ram_bist_master #(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          ADDR_WIDTH = 8,
  parameter int          TIMEOUT    = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        start_i,
  input  logic [1:0]  pattern_sel_i,
  input  logic [31:0] seed_i,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        pass_o,
  output logic        timeout_o,
  output logic [15:0] err_count_o,
  output logic [31:0] first_err_adr_o
);

  typedef enum logic [2:0] {IDLE, WR, WR_GAP, RD, RD_GAP, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = '1;
  localparam logic [15:0]           TO_LAST  = 16'(TIMEOUT - 1);

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0000_0000);
  endfunction

  function automatic logic [31:0] lfsr_init(input logic [31:0] sd);
    return (sd == 32'h0000_0000) ? 32'h0000_0001 : sd;
  endfunction

  function automatic logic [31:0] pattern(input logic [1:0] psel, input logic [31:0] sd,
                                          input logic [ADDR_WIDTH-1:0] idx, input logic [31:0] lf);
    case (psel)
      2'd0:    return sd;
      2'd1:    return 32'(idx);
      2'd2:    return sd ^ 32'(idx);
      default: return lf;
    endcase
  endfunction

  state_t                  state_r;
  logic [ADDR_WIDTH-1:0]   idx_r;
  logic [31:0]             lfsr_r;
  logic [31:0]             seed_r;
  logic [1:0]              psel_r;
  logic [15:0]             tcnt_r;

  logic [ADDR_WIDTH-1:0]   idx_inc_s;
  logic [31:0]             lfsr_adv_s;
  logic [31:0]             expected_s;

  assign idx_inc_s  = idx_r + 1'b1;
  assign lfsr_adv_s = lfsr_next(lfsr_r);
  assign expected_s = pattern(psel_r, seed_r, idx_r, lfsr_r);

  // Test sequencer: owns every bus and status output so they are all registered.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_r         <= IDLE;
      idx_r           <= '0;
      lfsr_r          <= 32'h0000_0000;
      seed_r          <= 32'h0000_0000;
      psel_r          <= 2'd0;
      tcnt_r          <= 16'h0000;
      wbm_cyc_o       <= 1'b0;
      wbm_stb_o       <= 1'b0;
      wbm_we_o        <= 1'b0;
      wbm_sel_o       <= 4'h0;
      wbm_adr_o       <= 32'h0000_0000;
      wbm_dat_o       <= 32'h0000_0000;
      busy_o          <= 1'b0;
      done_o          <= 1'b0;
      pass_o          <= 1'b0;
      timeout_o       <= 1'b0;
      err_count_o     <= 16'h0000;
      first_err_adr_o <= 32'h0000_0000;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (start_i) begin
            seed_r          <= seed_i;
            psel_r          <= pattern_sel_i;
            idx_r           <= '0;
            lfsr_r          <= lfsr_init(seed_i);
            tcnt_r          <= 16'h0000;
            done_o          <= 1'b0;
            pass_o          <= 1'b0;
            timeout_o       <= 1'b0;
            err_count_o     <= 16'h0000;
            first_err_adr_o <= 32'h0000_0000;
            busy_o          <= 1'b1;
            wbm_cyc_o       <= 1'b1;
            wbm_stb_o       <= 1'b1;
            wbm_we_o        <= 1'b1;
            wbm_sel_o       <= 4'hF;
            wbm_adr_o       <= BASE_ADDR;
            wbm_dat_o       <= pattern(pattern_sel_i, seed_i, '0, lfsr_init(seed_i));
            state_r         <= WR;
          end
        end
        WR, RD: begin
          if (wbm_ack_i) begin
            if (state_r == RD && wbm_dat_i != expected_s) begin
              if (err_count_o != 16'hFFFF) err_count_o <= err_count_o + 16'h0001;
              if (err_count_o == 16'h0000) first_err_adr_o <= wbm_adr_o;
            end
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_sel_o <= 4'h0;
            state_r   <= (state_r == WR) ? WR_GAP : RD_GAP;
          end else if (tcnt_r == TO_LAST) begin
            // Ack in the final allowed cycle is taken by the branch above.
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= 4'h0;
            wbm_adr_o <= 32'h0000_0000;
            wbm_dat_o <= 32'h0000_0000;
            timeout_o <= 1'b1;
            pass_o    <= 1'b0;
            done_o    <= 1'b1;
            busy_o    <= 1'b0;
            state_r   <= DONE;
          end else begin
            tcnt_r <= tcnt_r + 16'h0001;
          end
        end
        WR_GAP: begin
          tcnt_r    <= 16'h0000;
          wbm_cyc_o <= 1'b1;
          wbm_stb_o <= 1'b1;
          wbm_sel_o <= 4'hF;
          if (idx_r == LAST_IDX) begin
            idx_r     <= '0;
            lfsr_r    <= lfsr_init(seed_r);
            wbm_we_o  <= 1'b0;
            wbm_adr_o <= BASE_ADDR;
            wbm_dat_o <= 32'h0000_0000;
            state_r   <= RD;
          end else begin
            idx_r     <= idx_inc_s;
            lfsr_r    <= lfsr_adv_s;
            wbm_we_o  <= 1'b1;
            wbm_adr_o <= BASE_ADDR + 32'(idx_inc_s);
            wbm_dat_o <= pattern(psel_r, seed_r, idx_inc_s, lfsr_adv_s);
            state_r   <= WR;
          end
        end
        RD_GAP: begin
          if (idx_r == LAST_IDX) begin
            wbm_we_o  <= 1'b0;
            wbm_adr_o <= 32'h0000_0000;
            wbm_dat_o <= 32'h0000_0000;
            busy_o    <= 1'b0;
            done_o    <= 1'b1;
            pass_o    <= (err_count_o == 16'h0000) && !timeout_o;
            state_r   <= DONE;
          end else begin
            idx_r     <= idx_inc_s;
            lfsr_r    <= lfsr_adv_s;
            tcnt_r    <= 16'h0000;
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            wbm_sel_o <= 4'hF;
            wbm_adr_o <= BASE_ADDR + 32'(idx_inc_s);
            state_r   <= RD;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_ram_bist_master.sv
// Directed bench for wb_ram_bist_master: a table of complete runs against a
// configurable Wishbone RAM model, plus reset, busy-start and restart sequences.
module tb_wb_ram_bist_master;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  psel = 2'd0;
  logic [31:0] seed = 32'h0;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat_o;
  logic        ack = 1'b0;
  logic [31:0] dat_i = 32'h0;
  logic        busy, done, pass, tmo;
  logic [15:0] err_cnt;
  logic [31:0] first_adr;

  wb_ram_bist_master #(.BASE_ADDR(BASE), .ADDR_WIDTH(4), .TIMEOUT(8)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start), .pattern_sel_i(psel), .seed_i(seed),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel), .wbm_adr_o(adr),
    .wbm_dat_o(dat_o), .wbm_ack_i(ack), .wbm_dat_i(dat_i), .busy_o(busy), .done_o(done),
    .pass_o(pass), .timeout_o(tmo), .err_count_o(err_cnt), .first_err_adr_o(first_adr)
  );

  always #5 clk = ~clk;

  // RAM model state and run statistics
  logic [31:0] mem [16];
  logic [31:0] wlog_dat [16];
  logic [31:0] wlog_adr [16];
  int wcount = 0, delay = 0, stall = 0, cyc_cycles = 0, busy_cycles = 0, sel_bad = 0;
  logic flip_en = 1'b0;
  int errors = 0, checks = 0;

  // RAM model: responds on the falling edge so the DUT sees ack at the next rising edge
  always @(negedge clk) begin
    if (rst) begin
      ack = 1'b0;
      stall = 0;
    end else begin
      if (busy) busy_cycles++;
      if (cyc && stb) begin
        cyc_cycles++;
        if (sel != 4'hF) sel_bad++;
        if (stall == delay) begin
          ack = 1'b1;
          stall = 0;
          if (we) begin
            mem[adr[3:0]] = dat_o;
            if (wcount < 16) begin
              wlog_dat[wcount] = dat_o;
              wlog_adr[wcount] = adr;
            end
            wcount++;
          end else begin
            dat_i = mem[adr[3:0]];
            if (flip_en && (adr[3:0] == 4'd5 || adr[3:0] == 4'd9)) dat_i[0] = ~dat_i[0];
          end
        end else begin
          ack = 1'b0;
          stall++;
        end
      end else begin
        ack = 1'b0;
        stall = 0;
      end
    end
  end

  typedef struct {
    logic [1:0]  psel;
    logic [31:0] seed;
    logic        flip;
    int          delay;
    logic        exp_pass;
    logic        exp_to;
    logic [15:0] exp_err;
    logic [31:0] exp_first;
    int          exp_wcnt;
    logic [31:0] exp_w0;
    logic [31:0] exp_w1;
    int          exp_cyc;
    int          exp_busy;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic start_run(input logic [1:0] p, input logic [31:0] s, input int d, input logic f);
    delay = d;
    flip_en = f;
    wcount = 0;
    cyc_cycles = 0;
    busy_cycles = 0;
    sel_bad = 0;
    psel = p;
    seed = s;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done();
    for (int n = 0; n < 4000 && !done; n++) begin
      @(posedge clk);
      #1;
    end
    check("run_done", done, 1'b1);
  endtask

  task automatic run_vec(input int k);
    vec_t v;
    v = vecs[k];
    start_run(v.psel, v.seed, v.delay, v.flip);
    wait_done();
    check($sformatf("v%0d_pass", k), pass, v.exp_pass);
    check($sformatf("v%0d_timeout", k), tmo, v.exp_to);
    check($sformatf("v%0d_err_count", k), err_cnt, v.exp_err);
    check($sformatf("v%0d_first_err", k), first_adr, v.exp_first);
    check($sformatf("v%0d_busy", k), busy, 1'b0);
    check($sformatf("v%0d_bus_idle", k), {cyc, stb, we, sel, adr, dat_o}, 64'h0);
    check($sformatf("v%0d_writes", k), wcount, v.exp_wcnt);
    check($sformatf("v%0d_cyc_cycles", k), cyc_cycles, v.exp_cyc);
    check($sformatf("v%0d_busy_cycles", k), busy_cycles, v.exp_busy);
    check($sformatf("v%0d_sel", k), sel_bad, 0);
    if (v.exp_wcnt > 0) begin
      check($sformatf("v%0d_w0", k), wlog_dat[0], v.exp_w0);
      check($sformatf("v%0d_w1", k), wlog_dat[1], v.exp_w1);
      check($sformatf("v%0d_adr15", k), wlog_adr[15], BASE + 32'd15);
    end
  endtask

  initial begin
    vecs[0] = '{2'd1, 32'h0, 1'b0, 0, 1'b1, 1'b0, 16'd0, 32'h0, 16, 32'h0, 32'h1, 32, 64};
    vecs[1] = '{2'd0, 32'hDEAD_BEEF, 1'b1, 0, 1'b0, 1'b0, 16'd2, 32'h3000_0005, 16,
                32'hDEAD_BEEF, 32'hDEAD_BEEF, 32, 64};
    vecs[2] = '{2'd3, 32'h0, 1'b0, 0, 1'b1, 1'b0, 16'd0, 32'h0, 16, 32'h1, 32'h8020_0003, 32, 64};
    vecs[3] = '{2'd2, 32'hA5A5_0000, 1'b0, 0, 1'b1, 1'b0, 16'd0, 32'h0, 16,
                32'hA5A5_0000, 32'hA5A5_0001, 32, 64};
    vecs[4] = '{2'd1, 32'h0, 1'b0, 7, 1'b1, 1'b0, 16'd0, 32'h0, 16, 32'h0, 32'h1, 256, 288};
    vecs[5] = '{2'd1, 32'h0, 1'b0, 1000, 1'b0, 1'b1, 16'd0, 32'h0, 0, 32'h0, 32'h0, 8, 8};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {cyc, stb, we, sel, adr, dat_o, busy, done, pass, tmo, err_cnt, first_adr},
          64'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int k = 0; k < 6; k++) run_vec(k);

    // full 16-word image for the index pattern, taken from the first run
    run_vec(0);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("idx_data%0d", i), wlog_dat[i], 32'(i));
      check($sformatf("idx_adr%0d", i), wlog_adr[i], BASE + 32'(i));
    end

    // restart from DONE after a failing run clears results and restarts at index 0
    run_vec(1);
    start_run(2'd1, 32'h0, 0, 1'b0);
    check("restart_done_clr", done, 1'b0);
    check("restart_err_clr", err_cnt, 16'd0);
    check("restart_first_clr", first_adr, 32'h0);
    check("restart_busy", busy, 1'b1);
    check("restart_adr", adr, BASE);
    wait_done();
    check("restart_pass", pass, 1'b1);

    // start pulses while busy must not disturb the run
    start_run(2'd1, 32'h0, 0, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    psel = 2'd0;
    seed = 32'hFFFF_FFFF;
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1 start = 1'b0;
    wait_done();
    check("busy_start_pass", pass, 1'b1);
    check("busy_start_cyc", cyc_cycles, 32);
    check("busy_start_w7", wlog_dat[7], 32'd7);
    check("busy_start_w12", wlog_dat[12], 32'd12);

    // asynchronous reset in the middle of a write
    start_run(2'd1, 32'h0, 3, 1'b0);
    check("pre_rst_stb", {cyc, stb, we}, 3'b111);
    #2 rst = 1'b1;
    #1;
    check("async_rst_outputs", {cyc, stb, we, sel, adr, dat_o, busy, done, pass, tmo, err_cnt, first_adr},
          64'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    run_vec(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_ram_bist_master.md
Name: wb_ram_bist_master

Overview:
Wishbone classic initiator that runs a write-then-readback memory test against one Wishbone-attached OpenRAM port (e.g. port 0 of the dual-port RAM wrapper). It writes 2^ADDR_WIDTH words with a selectable data pattern, then reads every word back and compares it against the regenerated pattern. It reports pass/fail, an error count, the first failing address and an ack timeout. It is used for bring-up and self-test of RAM macros on the user project Wishbone bus.

Parameters:
BASE_ADDR, 32'h3000_0000, Wishbone base address of the RAM under test
ADDR_WIDTH, 8, log2 of the number of 32-bit words tested; word index occupies wbm_adr_o[ADDR_WIDTH-1:0] above BASE_ADDR
TIMEOUT, 255, maximum cycles waiting for ack per transaction (1..65535)

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  reset, asynchronous, active-high
start_i  in  1  start a test run (sampled when not busy)
pattern_sel_i  in  2  0=constant seed, 1=word index, 2=seed XOR index, 3=LFSR
seed_i  in  32  pattern seed, latched at start
wbm_cyc_o  out  1  Wishbone cycle
wbm_stb_o  out  1  Wishbone strobe
wbm_we_o  out  1  write enable
wbm_sel_o  out  4  byte selects, always 4'hF while stb is high, else 0
wbm_adr_o  out  32  address = BASE_ADDR + index
wbm_dat_o  out  32  write data
wbm_ack_i  in  1  slave acknowledge
wbm_dat_i  in  32  read data
busy_o  out  1  run in progress
done_o  out  1  run finished (sticky until next start)
pass_o  out  1  valid when done_o: no mismatches and no timeout
timeout_o  out  1  run aborted on ack timeout (sticky until next start)
err_count_o  out  16  mismatch count, saturating at 16'hFFFF
first_err_adr_o  out  32  address of the first mismatch, 0 if none

Behaviour:
- Reset is asynchronous and active-high. All outputs go to 0 immediately, including mid-transaction. The FSM goes to IDLE. The LFSR and counters clear.
- States: IDLE, WR, WR_GAP, RD, RD_GAP, DONE.
- IDLE or DONE with start_i=1: latch seed_i and pattern_sel_i, clear done/pass/timeout/err_count/first_err_adr, set index=0, set busy_o=1, go to WR. start_i is ignored while busy_o=1.
- WR: cyc=stb=we=1, sel=F, adr and dat stay stable until ack.
  - On a cycle with ack sampled high: deassert cyc/stb on the next edge and go to WR_GAP (one idle cycle).
  - From WR_GAP: if index = 2^ADDR_WIDTH-1, reset index=0, reload the pattern generator, and go to RD. Otherwise increment index and return to WR.
- RD: cyc=stb=1, we=0. On ack, compare wbm_dat_i against the expected pattern in that same cycle.
  - On mismatch: err_count+1 (saturating). If this is the first mismatch, capture adr into first_err_adr_o.
  - Then go to RD_GAP. RD_GAP either increments index and returns to RD, or, after the last word, goes to DONE.
- DONE: busy_o=0, done_o=1, pass_o = (err_count==0) and !timeout. Bus outputs are 0.
- Patterns (32-bit):
  - 0: seed
  - 1: zero-extended index
  - 2: seed ^ index
  - 3: Galois LFSR, initial state = seed, with seed 0 replaced by 1; next = (s>>1) ^ (s[0] ? 32'h8020_0003 : 0); advances once per word.
  - The read phase regenerates the identical sequence.
- Timeout: a counter resets when each WR/RD request starts and increments every cycle without ack. When it reaches TIMEOUT with no ack:
  - drop cyc/stb next edge;
  - set timeout_o=1, pass_o=0;
  - go to DONE.
  - An ack arriving in the same cycle the counter hits TIMEOUT counts as success.
- Ack while cyc/stb are low is ignored.
- Address arithmetic is modulo 2^32. The index never exceeds 2^ADDR_WIDTH-1.

Test Plan:
1. ADDR_WIDTH=4, pattern 1, zero-wait RAM model: 16 writes to 0x3000_0000..0x3000_000F with data 0..15, then 16 reads, cyc low exactly one cycle between transactions -> done_o=1, pass_o=1, err_count_o=0.
2. Pattern 0, seed 32'hDEAD_BEEF, model flips bit 0 on reads of index 5 and 9 -> err_count_o=2, first_err_adr_o=32'h3000_0005, pass_o=0.
3. Pattern 3, seed 0 -> first two writes carry 32'h0000_0001 and 32'h8020_0003. A clean readback gives pass_o=1.
4. TIMEOUT=8, model never acks -> cyc/stb drop after 8 stalled cycles, timeout_o=1, done_o=1, pass_o=0. Ack on exactly the 8th stalled cycle instead -> run continues.
5. Assert wb_rst_i asynchronously mid-write with stb high -> all outputs 0 before the next edge. A later start_i runs a full clean test and passes.
6. Pulse start_i while busy -> no effect on the sequence. Pulse start_i in DONE -> results clear and a new run begins at index 0.
